// File: rtl/conv_row_feeder.sv
// rtl/conv_row_feeder.sv - three-row padded window feeder for the conv_top row interface
module conv_row_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int D          = 4,
    parameter int H          = 12,
    parameter int W          = 12
) (
    input  logic                            clk,
    input  logic                            rstn_i,
    input  logic [D*W*DATA_WIDTH-1:0]       row_i,
    input  logic                            row_valid_i,
    output logic                            row_ready_o,
    output logic [D*(W+2)*DATA_WIDTH-1:0]   image0_o,
    output logic [D*(W+2)*DATA_WIDTH-1:0]   image1_o,
    output logic [D*(W+2)*DATA_WIDTH-1:0]   image2_o,
    output logic                            image_start_o,
    input  logic                            conv_done_i,
    output logic [$clog2(H)-1:0]            win_idx_o,
    output logic                            frame_done_o
);

    localparam int PAD_W = D * (W + 2) * DATA_WIDTH;
    localparam int WIN_W = $clog2(H);
    localparam int CNT_W = $clog2(H + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [PAD_W-1:0]   top;
    logic [PAD_W-1:0]   mid;
    logic [PAD_W-1:0]   bot;
    logic [PAD_W-1:0]   padded_row;
    logic [CNT_W-1:0]   rows_in;
    logic [WIN_W-1:0]   win;
    logic               frame_done;

    logic               ready_c;
    logic               start_c;
    logic               shift_en;
    logic               shift_zero;
    logic               inc_rows;
    logic               inc_win;
    logic               clear_all;
    logic               frame_done_set;

    // Insert one zero column on each side of every depth slice.
    always_comb begin
        padded_row = '0;
        for (int d = 0; d < D; d++) begin
            for (int w = 0; w < W; w++) begin
                padded_row[(d*(W+2) + w + 1)*DATA_WIDTH +: DATA_WIDTH] =
                    row_i[(d*W + w)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rstn_i) begin
        if (rstn_i) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_next     = state;
        ready_c        = 1'b0;
        start_c        = 1'b0;
        shift_en       = 1'b0;
        shift_zero     = 1'b0;
        inc_rows       = 1'b0;
        inc_win        = 1'b0;
        clear_all      = 1'b0;
        frame_done_set = 1'b0;
        case (state)
            ST_FILL: begin
                ready_c = 1'b1;
                if (row_valid_i) begin
                    shift_en = 1'b1;
                    inc_rows = 1'b1;
                    if ((rows_in + CNT_W'(1)) == (CNT_W'(win) + CNT_W'(2))) begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                start_c    = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_done_i) begin
                    if (win == WIN_W'(H - 1)) begin
                        clear_all      = 1'b1;
                        frame_done_set = 1'b1;
                        state_next     = ST_FILL;
                    end else if (rows_in < CNT_W'(H)) begin
                        inc_win    = 1'b1;
                        state_next = ST_FILL;
                    end else begin
                        // Bottom padding row: the window advances without an accept.
                        inc_win    = 1'b1;
                        shift_en   = 1'b1;
                        shift_zero = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Row window, counters and the registered frame-done pulse.
    always_ff @(posedge clk or posedge rstn_i) begin
        if (rstn_i) begin
            top        <= '0;
            mid        <= '0;
            bot        <= '0;
            rows_in    <= '0;
            win        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_done_set;
            if (clear_all) begin
                top     <= '0;
                mid     <= '0;
                bot     <= '0;
                rows_in <= '0;
                win     <= '0;
            end else begin
                if (shift_en) begin
                    top <= mid;
                    mid <= bot;
                    bot <= shift_zero ? '0 : padded_row;
                end
                if (inc_rows) begin
                    rows_in <= rows_in + CNT_W'(1);
                end
                if (inc_win) begin
                    win <= win + WIN_W'(1);
                end
            end
        end
    end

    // Ready is held low while reset is asserted even though the state is already FILL.
    assign row_ready_o   = ready_c & ~rstn_i;
    assign image_start_o = start_c;
    assign image0_o      = top;
    assign image1_o      = mid;
    assign image2_o      = bot;
    assign win_idx_o     = win;
    assign frame_done_o  = frame_done;

endmodule

// File: tb/tb_conv_row_feeder.sv
// tb/tb_conv_row_feeder.sv - directed self-checking bench for conv_row_feeder
module tb_conv_row_feeder;

    localparam int DW = 8;
    localparam int D  = 4;
    localparam int H  = 12;
    localparam int W  = 12;
    localparam int RW = D * W * DW;
    localparam int PW = D * (W + 2) * DW;
    localparam int SW = (W + 2) * DW;
    localparam int IW = $clog2(H);

    logic          clk = 1'b0;
    logic          rstn_i;
    logic [RW-1:0] row_i;
    logic          row_valid_i;
    logic          row_ready_o;
    logic [PW-1:0] image0_o;
    logic [PW-1:0] image1_o;
    logic [PW-1:0] image2_o;
    logic          image_start_o;
    logic          conv_done_i;
    logic [IW-1:0] win_idx_o;
    logic          frame_done_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [PW-1:0] w0_img1;
    logic [PW-1:0] w11_img0;
    logic [PW-1:0] w11_img1;
    logic [PW-1:0] w11_img2;

    conv_row_feeder #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
        .clk           (clk),
        .rstn_i        (rstn_i),
        .row_i         (row_i),
        .row_valid_i   (row_valid_i),
        .row_ready_o   (row_ready_o),
        .image0_o      (image0_o),
        .image1_o      (image1_o),
        .image2_o      (image2_o),
        .image_start_o (image_start_o),
        .conv_done_i   (conv_done_i),
        .win_idx_o     (win_idx_o),
        .frame_done_o  (frame_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pix(input int mode, input int r, input int d, input int w);
        if (mode == 0) return DW'(r + 1);
        return DW'(r * 7 + d * 13 + w * 3 + 1);
    endfunction

    function automatic logic [RW-1:0] mk_row(input int mode, input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int d = 0; d < D; d++)
            for (int w = 0; w < W; w++)
                v[(d*W + w)*DW +: DW] = pix(mode, r, d, w);
        return v;
    endfunction

    function automatic logic [PW-1:0] exp_pad(input int mode, input int r);
        logic [PW-1:0] v;
        v = '0;
        if (r >= 0 && r < H)
            for (int d = 0; d < D; d++)
                for (int w = 0; w < W; w++)
                    v[d*SW + (w + 1)*DW +: DW] = pix(mode, r, d, w);
        return v;
    endfunction

    task automatic run_frames(input int mode, input int nframes, input int gap,
                              input bit stray, input int abort_win, output bit aborted);
        int sent = 0;
        int starts = 0;
        int fdone = 0;
        int cd = 0;
        int last_acc = -100;
        int last_done = -100;
        int fd_cyc = -100;
        int gap_left;
        int r;
        int exp_cyc;
        bit in_wait = 0;
        bit abort_pending = 0;
        logic [PW-1:0] s0, s1, s2;
        gap_left = gap;
        aborted = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (abort_pending) begin
                aborted = 1;
                conv_done_i = 1'b0;
                row_valid_i = 1'b0;
                break;
            end
            if (in_wait) begin
                checks++;
                if (row_ready_o !== 1'b0 || image0_o !== s0 || image1_o !== s1 || image2_o !== s2) begin
                    errors++;
                    $display("FAIL wait_hold cyc=%0d ready=%b (required 0) or image ports moved", cyc, row_ready_o);
                end
            end
            if (image_start_o) begin
                r = starts % H;
                exp_cyc = (r <= H - 2) ? last_acc + 1 : last_done + 1;
                checks++;
                if (win_idx_o !== IW'(r)) begin
                    errors++;
                    $display("FAIL win_idx got %0d required %0d", win_idx_o, r);
                end
                checks++;
                if (cyc != exp_cyc) begin
                    errors++;
                    $display("FAIL start_timing win %0d at cycle %0d required %0d", r, cyc, exp_cyc);
                end
                checks++;
                if (row_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL issue_ready win %0d got %b required 0", r, row_ready_o);
                end
                checks++;
                if (image0_o !== exp_pad(mode, r - 1)) begin
                    errors++;
                    $display("FAIL image0 win %0d got %h required %h", r, image0_o, exp_pad(mode, r - 1));
                end
                checks++;
                if (image1_o !== exp_pad(mode, r)) begin
                    errors++;
                    $display("FAIL image1 win %0d got %h required %h", r, image1_o, exp_pad(mode, r));
                end
                checks++;
                if (image2_o !== exp_pad(mode, r + 1)) begin
                    errors++;
                    $display("FAIL image2 win %0d got %h required %h", r, image2_o, exp_pad(mode, r + 1));
                end
                if (r == 0) w0_img1 = image1_o;
                if (r == H - 1) begin
                    w11_img0 = image0_o;
                    w11_img1 = image1_o;
                    w11_img2 = image2_o;
                end
                s0 = image0_o;
                s1 = image1_o;
                s2 = image2_o;
                in_wait = 1;
                cd = 3;
                starts++;
                if (r == abort_win) abort_pending = 1;
            end
            if (frame_done_o) begin
                checks++;
                if (cyc != fd_cyc || row_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_done at cycle %0d ready=%b required cycle %0d ready 1", cyc, row_ready_o, fd_cyc);
                end
                fdone++;
            end
            conv_done_i = 1'b0;
            if (cd > 0 && !image_start_o) begin
                cd--;
                if (cd == 0) begin
                    conv_done_i = 1'b1;
                    last_done = cyc;
                    in_wait = 0;
                    if (starts % H == 0) fd_cyc = cyc + 1;
                end
            end
            if (stray && image_start_o) conv_done_i = 1'b1;
            if (sent == 1 && gap_left > 0) begin
                row_valid_i = 1'b0;
                gap_left--;
            end else if (sent < nframes * H) begin
                row_valid_i = 1'b1;
                row_i = mk_row(mode, sent % H);
            end else begin
                row_valid_i = 1'b0;
            end
            if (row_valid_i && row_ready_o) begin
                sent++;
                last_acc = cyc;
            end
            if (fdone == nframes && !abort_pending) break;
        end
        row_valid_i = 1'b0;
        conv_done_i = 1'b0;
        if (!aborted) begin
            checks++;
            if (starts != nframes * H || fdone != nframes) begin
                errors++;
                $display("FAIL frame_counts starts=%0d frame_done=%0d required %0d and %0d",
                         starts, fdone, nframes * H, nframes);
            end
        end
    endtask

    task automatic test_reset;
        rstn_i = 1'b1;
        row_valid_i = 1'b0;
        conv_done_i = 1'b0;
        row_i = '0;
        @(negedge clk);
        checks++;
        if (image0_o !== '0 || image1_o !== '0 || image2_o !== '0 || image_start_o !== 1'b0 ||
            frame_done_o !== 1'b0 || win_idx_o !== '0 || row_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b start=%b fd=%b win=%0d required all 0",
                     row_ready_o, image_start_o, frame_done_o, win_idx_o);
        end
        rstn_i = 1'b0;
        #1;
        checks++;
        if (row_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", row_ready_o);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (image_start_o !== 1'b0 || frame_done_o !== 1'b0 || row_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL idle start=%b fd=%b ready=%b required 0 0 1",
                         image_start_o, frame_done_o, row_ready_o);
            end
        end
    endtask

    task automatic test_full_frame;
        bit ab;
        logic [SW-1:0] exp_s;
        run_frames(0, 1, 0, 0, -1, ab);
        exp_s = {8'h00, {12{8'h01}}, 8'h00};
        checks++;
        if (w0_img1[0 +: SW] !== exp_s || w0_img1[3*SW +: SW] !== exp_s) begin
            errors++;
            $display("FAIL w0_image1_slices got %h required slices %h", w0_img1, exp_s);
        end
        exp_s = {8'h00, {12{8'h0B}}, 8'h00};
        checks++;
        if (w11_img0[2*SW +: SW] !== exp_s) begin
            errors++;
            $display("FAIL w11_image0_slice2 got %h required %h", w11_img0[2*SW +: SW], exp_s);
        end
        exp_s = {8'h00, {12{8'h0C}}, 8'h00};
        checks++;
        if (w11_img1[SW +: SW] !== exp_s || w11_img2 !== '0) begin
            errors++;
            $display("FAIL w11_image1_image2 got %h / %h required %h / 0", w11_img1[SW +: SW], w11_img2, exp_s);
        end
    endtask

    task automatic test_backpressure_stray_done;
        bit ab;
        run_frames(0, 1, 0, 1, -1, ab);
    endtask

    task automatic test_gapped_input;
        bit ab;
        run_frames(1, 1, 5, 0, -1, ab);
    endtask

    task automatic test_reset_mid_frame;
        bit ab;
        run_frames(0, 1, 0, 0, 5, ab);
        checks++;
        if (!ab) begin
            errors++;
            $display("FAIL mid_abort_reached got %0d required 1", ab);
        end
        rstn_i = 1'b1;
        #1;
        checks++;
        if (image0_o !== '0 || image1_o !== '0 || image2_o !== '0 || win_idx_o !== '0 ||
            row_ready_o !== 1'b0 || image_start_o !== 1'b0 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear win=%0d ready=%b start=%b fd=%b required all 0",
                     win_idx_o, row_ready_o, image_start_o, frame_done_o);
        end
        @(negedge clk);
        rstn_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (frame_done_o !== 1'b0 || image_start_o !== 1'b0 || row_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle fd=%b start=%b ready=%b required 0 0 1",
                         frame_done_o, image_start_o, row_ready_o);
            end
        end
        run_frames(0, 1, 0, 0, -1, ab);
    endtask

    task automatic test_back_to_back;
        bit ab;
        run_frames(1, 2, 0, 0, -1, ab);
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_backpressure_stray_done;
        test_gapped_input;
        test_reset_mid_frame;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
